sw_score_max_reduce: RTL and testbench
======================================

Name: sw_score_max_reduce

Overview:
- Parametrised, pipelined max-reduction tree for Smith-Waterman PE-array scores.
- Each beat, it reduces NUM_IN signed lane scores to one clamped maximum and the index of the lane that produced it.
- Across the beats of a frame (one query/database pass), it keeps a running best score and reports it with lane and beat position at frame end.
- Sits between the PE array score taps and the traceback/result controller.

Parameters:
- DATA_WIDTH, 16: width of each two's-complement lane score.
- NUM_IN, 64: lane count, >= 2; the tree pads missing leaves with 0.
- RADIX, 8: comparator fan-in per tree level, >= 2.
- BEAT_WIDTH, 16: width of the beat counter and frame_beat.
- Derived localparams:
  - LEVELS = ceil(log_RADIX(NUM_IN)).
  - IDX_WIDTH = max(1, ceil(log2(NUM_IN))).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of pipeline and accumulator
- in_valid  in  1  beat valid
- in_last  in  1  last beat of frame; qualified by in_valid
- in_data  in  DATA_WIDTH*NUM_IN  lane scores; lane k occupies bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
- beat_valid  out  1  per-beat result valid
- beat_max  out  DATA_WIDTH  clamped beat maximum
- beat_lane  out  IDX_WIDTH  winning lane of the beat
- frame_valid  out  1  one-cycle pulse, frame result valid
- frame_max  out  DATA_WIDTH  frame maximum
- frame_lane  out  IDX_WIDTH  lane of frame maximum
- frame_beat  out  BEAT_WIDTH  beat index within frame of frame maximum

Behaviour:
- Clamp rule: every lane is first mapped to max(x, 0); negative scores count as 0. All outputs are non-negative.
- Compare rule, within a node: the larger value wins; on a tie, the lower lane index wins.
- Compare rule, across beats: the running best is replaced only on strictly greater, so the earliest beat wins ties.
- Tree pipeline:
  - LEVELS register stages; each stage holds value, lane index and a valid bit.
  - The valid bit and a last bit travel with the data.
  - No backpressure: the pipeline advances every cycle; bubbles (in_valid=0) propagate as invalid.
- Latency:
  - Beat accepted at edge t gives beat_valid/beat_max/beat_lane registered at edge t+LEVELS.
  - Default parameters: LEVELS=2.
- Accumulator stage, one register level after the tree:
  - On a valid tree output, run_max/run_lane/run_beat update per the across-beat rule.
  - The first valid beat of a frame always loads.
  - beat_cnt increments per valid beat and saturates at all-ones; saturated beats report frame_beat = all-ones.
  - If the beat also carries last: frame_valid pulses, frame_* are loaded from the post-update running values, and the accumulator rearms for a new frame (beat_cnt=0, first-beat flag set).
  - frame_valid rises at edge t+LEVELS+1 after the last beat is accepted.
- frame_* hold their values until the next frame_valid.
- beat_valid and frame_valid are single-cycle when the input is single-beat.
- Single-beat frame (in_last on the first beat) is legal: frame_beat=0.
- Back-to-back frames with no bubble are legal; no beat is lost.
- Frames that have not completed when clear or reset occurs produce no frame_valid.
- clear:
  - Zeroes all stage valids, the accumulator, beat_cnt and the first-beat flag.
  - Takes priority over a same-cycle in_valid; that beat is dropped.
  - Does not alter frame_max, frame_lane or frame_beat.
- Reset values: all outputs 0; all internal valids 0; first-beat flag set.
- Reset mid-frame: the partial frame is discarded.

Optional Feature:
- Macro SW_SCORE_MAX_THRESH_EN.
- When defined:
  - Adds input thresh [DATA_WIDTH-1:0], sampled each cycle.
  - Adds output thresh_hit, 1 bit, reset 0.
  - Adds output early_hit, 1 bit, reset 0.
  - thresh_hit is registered with frame_valid and is 1 iff frame_max >= thresh, compared unsigned after clamp.
  - early_hit pulses one cycle at the accumulator stage on the first beat of a frame whose running max reaches >= thresh.
  - early_hit fires at most once per frame and rearms at frame end, on clear, or on reset.
- When undefined: the ports and the logic are absent.

Test Plan:
- Defaults; one beat, in_last=1, lane 37=500, others in 0..100 → beat_valid at t+2 with beat_max=500, beat_lane=37; frame_valid at t+3 with frame_max=500, frame_lane=37, frame_beat=0.
- All lanes negative (-5) → beat_max=0, beat_lane=0.
- Lanes 10 and 50 both = 200, rest 0 → beat_lane=10.
- 4-beat frame, maxima 30, 90, 90, 60 in lanes 3, 7, 2, 1, with one bubble between beats 1 and 2 → frame_max=90, frame_lane=7, frame_beat=1, frame_valid exactly once.
- Two back-to-back 2-beat frames (maxima 5 then 40) → two frame_valid pulses, 2 cycles apart, frame_max 5 then 40.
- Mid-frame clear asserted with an in_valid beat of 999 → no frame_valid; the next frame with max 12 reports frame_max=12, frame_beat=0.
- Mid-frame rst_n pulse → all outputs 0; the partial frame produces no frame_valid.
- With SW_SCORE_MAX_THRESH_EN, thresh=100, beats with maxima 50, 120, 150 → early_hit once on beat 1; thresh_hit=1 at frame end.
- Non-power parameters NUM_IN=10, RADIX=4 (LEVELS=2): lane 9=77 → beat_max=77, beat_lane=9, latency 2.

Source files
------------

// File: rtl/sw_score_max_reduce.sv
// Pipelined clamped max-reduction tree over PE-array lane scores with per-frame best tracking.
// Define SW_SCORE_MAX_THRESH_EN to add threshold detection (thresh, thresh_hit, early_hit).
module sw_score_max_reduce #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 64,
  parameter int unsigned RADIX      = 8,
  parameter int unsigned BEAT_WIDTH = 16,
  localparam int unsigned IDX_WIDTH = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [DATA_WIDTH*NUM_IN-1:0] in_data,
  output logic                         beat_valid,
  output logic [DATA_WIDTH-1:0]        beat_max,
  output logic [IDX_WIDTH-1:0]         beat_lane,
  output logic                         frame_valid,
  output logic [DATA_WIDTH-1:0]        frame_max,
  output logic [IDX_WIDTH-1:0]         frame_lane,
  output logic [BEAT_WIDTH-1:0]        frame_beat
`ifdef SW_SCORE_MAX_THRESH_EN
  ,
  input  logic [DATA_WIDTH-1:0]        thresh,
  output logic                         thresh_hit,
  output logic                         early_hit
`endif
);

  function automatic int unsigned calc_levels(input int unsigned n, input int unsigned r);
    int unsigned lv;
    int unsigned span;
    lv   = 0;
    span = 1;
    while (span < n) begin
      span = span * r;
      lv++;
    end
    return lv;
  endfunction

  function automatic int unsigned ipow(input int unsigned b, input int unsigned e);
    int unsigned acc;
    acc = 1;
    for (int unsigned i = 0; i < e; i++) acc = acc * b;
    return acc;
  endfunction

  localparam int unsigned LEVELS = calc_levels(NUM_IN, RADIX);
  localparam int unsigned PAD    = ipow(RADIX, LEVELS);
  localparam int unsigned NODE_W = (PAD > 2) ? $clog2(PAD) : 1;

  // Offset of the first node of tree level l in the flattened node arrays.
  function automatic int unsigned node_off(input int unsigned l);
    int unsigned acc;
    acc = 0;
    for (int unsigned j = 0; j < l; j++) acc = acc + PAD / ipow(RADIX, j + 1);
    return acc;
  endfunction

  localparam int unsigned TOT = node_off(LEVELS);

  // Strictly-greater scan: earlier children (lower lanes) keep ties.
  function automatic logic [DATA_WIDTH+NODE_W-1:0] pick(
    input logic [RADIX*DATA_WIDTH-1:0] vals,
    input logic [RADIX*NODE_W-1:0]     idxs
  );
    logic [DATA_WIDTH-1:0] best_v;
    logic [NODE_W-1:0]     best_i;
    best_v = vals[DATA_WIDTH-1:0];
    best_i = idxs[NODE_W-1:0];
    for (int unsigned c = 1; c < RADIX; c++) begin
      if (vals[c*DATA_WIDTH +: DATA_WIDTH] > best_v) begin
        best_v = vals[c*DATA_WIDTH +: DATA_WIDTH];
        best_i = idxs[c*NODE_W +: NODE_W];
      end
    end
    return {best_v, best_i};
  endfunction

  logic [PAD*DATA_WIDTH-1:0] leaf_val;
  logic [PAD*NODE_W-1:0]     leaf_idx;

  // Clamp negatives to zero; leaves beyond NUM_IN are zero and sit after every real lane.
  for (genvar k = 0; k < PAD; k++) begin : g_leaf
    if (k < NUM_IN) begin : g_lane
      logic [DATA_WIDTH-1:0] raw;
      assign raw = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      assign leaf_val[k*DATA_WIDTH +: DATA_WIDTH] = raw[DATA_WIDTH-1] ? '0 : raw;
    end else begin : g_pad
      assign leaf_val[k*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
    assign leaf_idx[k*NODE_W +: NODE_W] = NODE_W'(k);
  end

  logic [DATA_WIDTH-1:0] node_val_d [TOT];
  logic [NODE_W-1:0]     node_idx_d [TOT];
  logic [DATA_WIDTH-1:0] node_val_q [TOT];
  logic [NODE_W-1:0]     node_idx_q [TOT];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned NN  = PAD / ipow(RADIX, l + 1);
    localparam int unsigned OFF = node_off(l);
    logic [NN*RADIX*DATA_WIDTH-1:0] src_val;
    logic [NN*RADIX*NODE_W-1:0]     src_idx;
    if (l == 0) begin : g_src_leaf
      assign src_val = leaf_val;
      assign src_idx = leaf_idx;
    end else begin : g_src_node
      localparam int unsigned PREV = node_off(l - 1);
      for (genvar k = 0; k < NN*RADIX; k++) begin : g_k
        assign src_val[k*DATA_WIDTH +: DATA_WIDTH] = node_val_q[PREV+k];
        assign src_idx[k*NODE_W +: NODE_W]         = node_idx_q[PREV+k];
      end
    end
    for (genvar n = 0; n < NN; n++) begin : g_node
      assign {node_val_d[OFF+n], node_idx_d[OFF+n]} =
        pick(src_val[n*RADIX*DATA_WIDTH +: RADIX*DATA_WIDTH], src_idx[n*RADIX*NODE_W +: RADIX*NODE_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TOT; i++) begin
        node_val_q[i] <= '0;
        node_idx_q[i] <= '0;
      end
    end else begin
      node_val_q <= node_val_d;
      node_idx_q <= node_idx_d;
    end
  end

  // Valid and last travel alongside the tree data; clear flushes them.
  logic [LEVELS-1:0] vld_d, vld_q, last_d, last_q;

  always_comb begin
    vld_d  = '0;
    last_d = '0;
    if (!clear) begin
      vld_d[0]  = in_valid;
      last_d[0] = in_valid & in_last;
      for (int unsigned s = 1; s < LEVELS; s++) begin
        vld_d[s]  = vld_q[s-1];
        last_d[s] = last_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  logic                  beat_valid_d, beat_valid_q, beat_last_d, beat_last_q;
  logic [DATA_WIDTH-1:0] beat_max_d, beat_max_q, run_max_d, run_max_q, frame_max_d, frame_max_q;
  logic [IDX_WIDTH-1:0]  beat_lane_d, beat_lane_q, run_lane_d, run_lane_q, frame_lane_d, frame_lane_q;
  logic [BEAT_WIDTH-1:0] run_beat_d, run_beat_q, beat_cnt_d, beat_cnt_q, frame_beat_d, frame_beat_q;
  logic                  first_d, first_q, frame_valid_d, frame_valid_q;
  logic                  take;
  logic [DATA_WIDTH-1:0] nxt_max;
  logic [IDX_WIDTH-1:0]  nxt_lane;
  logic [BEAT_WIDTH-1:0] nxt_beat;
`ifdef SW_SCORE_MAX_THRESH_EN
  logic armed_d, armed_q, early_hit_d, early_hit_q, thresh_hit_d, thresh_hit_q;
`endif

  // Beat output register followed by the across-beat accumulator.
  always_comb begin
    beat_valid_d  = vld_q[LEVELS-1];
    beat_last_d   = last_q[LEVELS-1];
    beat_max_d    = node_val_q[TOT-1];
    beat_lane_d   = IDX_WIDTH'(node_idx_q[TOT-1]);
    run_max_d     = run_max_q;
    run_lane_d    = run_lane_q;
    run_beat_d    = run_beat_q;
    beat_cnt_d    = beat_cnt_q;
    first_d       = first_q;
    frame_valid_d = 1'b0;
    frame_max_d   = frame_max_q;
    frame_lane_d  = frame_lane_q;
    frame_beat_d  = frame_beat_q;
    take          = first_q || (beat_max_q > run_max_q);
    nxt_max       = take ? beat_max_q  : run_max_q;
    nxt_lane      = take ? beat_lane_q : run_lane_q;
    nxt_beat      = take ? beat_cnt_q  : run_beat_q;
`ifdef SW_SCORE_MAX_THRESH_EN
    armed_d       = armed_q;
    early_hit_d   = 1'b0;
    thresh_hit_d  = thresh_hit_q;
`endif
    if (clear) begin
      beat_valid_d = 1'b0;
      beat_last_d  = 1'b0;
      run_max_d    = '0;
      run_lane_d   = '0;
      run_beat_d   = '0;
      beat_cnt_d   = '0;
      first_d      = 1'b0;
`ifdef SW_SCORE_MAX_THRESH_EN
      armed_d      = 1'b1;
`endif
    end else if (beat_valid_q) begin
`ifdef SW_SCORE_MAX_THRESH_EN
      if (armed_q && (nxt_max >= thresh)) begin
        early_hit_d = 1'b1;
        armed_d     = 1'b0;
      end
`endif
      if (beat_last_q) begin
        frame_valid_d = 1'b1;
        frame_max_d   = nxt_max;
        frame_lane_d  = nxt_lane;
        frame_beat_d  = nxt_beat;
        run_max_d     = '0;
        run_lane_d    = '0;
        run_beat_d    = '0;
        beat_cnt_d    = '0;
        first_d       = 1'b1;
`ifdef SW_SCORE_MAX_THRESH_EN
        thresh_hit_d  = (nxt_max >= thresh);
        armed_d       = 1'b1;
`endif
      end else begin
        run_max_d  = nxt_max;
        run_lane_d = nxt_lane;
        run_beat_d = nxt_beat;
        beat_cnt_d = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + BEAT_WIDTH'(1);
        first_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_valid_q  <= 1'b0;
      beat_last_q   <= 1'b0;
      beat_max_q    <= '0;
      beat_lane_q   <= '0;
      run_max_q     <= '0;
      run_lane_q    <= '0;
      run_beat_q    <= '0;
      beat_cnt_q    <= '0;
      first_q       <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_max_q   <= '0;
      frame_lane_q  <= '0;
      frame_beat_q  <= '0;
`ifdef SW_SCORE_MAX_THRESH_EN
      armed_q       <= 1'b1;
      early_hit_q   <= 1'b0;
      thresh_hit_q  <= 1'b0;
`endif
    end else begin
      beat_valid_q  <= beat_valid_d;
      beat_last_q   <= beat_last_d;
      beat_max_q    <= beat_max_d;
      beat_lane_q   <= beat_lane_d;
      run_max_q     <= run_max_d;
      run_lane_q    <= run_lane_d;
      run_beat_q    <= run_beat_d;
      beat_cnt_q    <= beat_cnt_d;
      first_q       <= first_d;
      frame_valid_q <= frame_valid_d;
      frame_max_q   <= frame_max_d;
      frame_lane_q  <= frame_lane_d;
      frame_beat_q  <= frame_beat_d;
`ifdef SW_SCORE_MAX_THRESH_EN
      armed_q       <= armed_d;
      early_hit_q   <= early_hit_d;
      thresh_hit_q  <= thresh_hit_d;
`endif
    end
  end

  assign beat_valid  = beat_valid_q;
  assign beat_max    = beat_max_q;
  assign beat_lane   = beat_lane_q;
  assign frame_valid = frame_valid_q;
  assign frame_max   = frame_max_q;
  assign frame_lane  = frame_lane_q;
  assign frame_beat  = frame_beat_q;
`ifdef SW_SCORE_MAX_THRESH_EN
  assign thresh_hit  = thresh_hit_q;
  assign early_hit   = early_hit_q;
`endif

endmodule

// File: tb/tb_sw_score_max_reduce.sv
// Scoreboard bench for sw_score_max_reduce: default 64/8 instance plus a 10-lane radix-4 instance.
module tb_sw_score_max_reduce;
  localparam int unsigned DW  = 16;
  localparam int unsigned N1  = 64;
  localparam int unsigned N2  = 10;
  localparam int          LAT = 2;

  typedef struct {
    int mx;
    int lane;
    int bt;
    int th;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic              clear1, in_valid1, in_last1;
  logic [DW*N1-1:0]  in_data1, v1;
  logic              beat_valid1, frame_valid1;
  logic [DW-1:0]     beat_max1, frame_max1;
  logic [5:0]        beat_lane1, frame_lane1;
  logic [15:0]       frame_beat1;
`ifdef SW_SCORE_MAX_THRESH_EN
  logic [DW-1:0]     thresh1;
  logic              thresh_hit1, early_hit1;
`endif

  logic              clear2, in_valid2, in_last2;
  logic [DW*N2-1:0]  in_data2, v2;
  logic              beat_valid2, frame_valid2;
  logic [DW-1:0]     beat_max2, frame_max2;
  logic [3:0]        beat_lane2, frame_lane2;
  logic [1:0]        frame_beat2;
`ifdef SW_SCORE_MAX_THRESH_EN
  logic [DW-1:0]     thresh2;
  logic              thresh_hit2, early_hit2;
`endif

  exp_t bq1[$], fq1[$], bq2[$], fq2[$];
  int   eq1[$];
  exp_t e1, e2;

  sw_score_max_reduce dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_last(in_last1),
    .in_data(in_data1), .beat_valid(beat_valid1), .beat_max(beat_max1), .beat_lane(beat_lane1),
    .frame_valid(frame_valid1), .frame_max(frame_max1), .frame_lane(frame_lane1),
    .frame_beat(frame_beat1)
`ifdef SW_SCORE_MAX_THRESH_EN
    , .thresh(thresh1), .thresh_hit(thresh_hit1), .early_hit(early_hit1)
`endif
  );

  sw_score_max_reduce #(.DATA_WIDTH(16), .NUM_IN(10), .RADIX(4), .BEAT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(in_valid2), .in_last(in_last2),
    .in_data(in_data2), .beat_valid(beat_valid2), .beat_max(beat_max2), .beat_lane(beat_lane2),
    .frame_valid(frame_valid2), .frame_max(frame_max2), .frame_lane(frame_lane2),
    .frame_beat(frame_beat2)
`ifdef SW_SCORE_MAX_THRESH_EN
    , .thresh(thresh2), .thresh_hit(thresh_hit2), .early_hit(early_hit2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (beat_valid1) begin
        if (bq1.size() == 0) check("dut1 unexpected beat_valid", int'(beat_valid1), 0);
        else begin
          e1 = bq1.pop_front();
          check("dut1 beat_max", int'(beat_max1), e1.mx);
          check("dut1 beat_lane", int'(beat_lane1), e1.lane);
          check("dut1 beat cycle", cyc, e1.cyc);
        end
      end
      if (frame_valid1) begin
        if (fq1.size() == 0) check("dut1 unexpected frame_valid", int'(frame_valid1), 0);
        else begin
          e1 = fq1.pop_front();
          check("dut1 frame_max", int'(frame_max1), e1.mx);
          check("dut1 frame_lane", int'(frame_lane1), e1.lane);
          check("dut1 frame_beat", int'(frame_beat1), e1.bt);
          check("dut1 frame cycle", cyc, e1.cyc);
`ifdef SW_SCORE_MAX_THRESH_EN
          check("dut1 thresh_hit", int'(thresh_hit1), e1.th);
`endif
        end
      end
`ifdef SW_SCORE_MAX_THRESH_EN
      if (early_hit1) begin
        if (eq1.size() == 0) check("dut1 unexpected early_hit", int'(early_hit1), 0);
        else check("dut1 early_hit cycle", cyc, eq1.pop_front());
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (beat_valid2) begin
        if (bq2.size() == 0) check("dut2 unexpected beat_valid", int'(beat_valid2), 0);
        else begin
          e2 = bq2.pop_front();
          check("dut2 beat_max", int'(beat_max2), e2.mx);
          check("dut2 beat_lane", int'(beat_lane2), e2.lane);
          check("dut2 beat cycle", cyc, e2.cyc);
        end
      end
      if (frame_valid2) begin
        if (fq2.size() == 0) check("dut2 unexpected frame_valid", int'(frame_valid2), 0);
        else begin
          e2 = fq2.pop_front();
          check("dut2 frame_max", int'(frame_max2), e2.mx);
          check("dut2 frame_lane", int'(frame_lane2), e2.lane);
          check("dut2 frame_beat", int'(frame_beat2), e2.bt);
          check("dut2 frame cycle", cyc, e2.cyc);
        end
      end
    end
  end

  task automatic lane1(input int k, input int val);
    v1[k*DW +: DW] = DW'(val);
  endtask

  task automatic lane2(input int k, input int val);
    v2[k*DW +: DW] = DW'(val);
  endtask

  task automatic send1(input bit last, input int bmx, input int bln,
                       input int fmx, input int fln, input int fbt, input int fth);
    @(negedge clk);
    in_data1  = v1;
    in_valid1 = 1'b1;
    in_last1  = last;
    bq1.push_back('{bmx, bln, 0, 0, cyc + 1 + LAT});
    if (last) fq1.push_back('{fmx, fln, fbt, fth, cyc + 2 + LAT});
  endtask

  task automatic send2(input bit last, input int bmx, input int bln,
                       input int fmx, input int fln, input int fbt);
    @(negedge clk);
    in_data2  = v2;
    in_valid2 = 1'b1;
    in_last2  = last;
    bq2.push_back('{bmx, bln, 0, 0, cyc + 1 + LAT});
    if (last) fq2.push_back('{fmx, fln, fbt, 0, cyc + 2 + LAT});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid1 = 1'b0;
      in_last1  = 1'b0;
      in_valid2 = 1'b0;
      in_last2  = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear1 = 1'b0; in_valid1 = 1'b0; in_last1 = 1'b0; in_data1 = '0; v1 = '0;
    clear2 = 1'b0; in_valid2 = 1'b0; in_last2 = 1'b0; in_data2 = '0; v2 = '0;
`ifdef SW_SCORE_MAX_THRESH_EN
    thresh1 = 16'hFFFF;
    thresh2 = 16'hFFFF;
`endif
    repeat (3) @(negedge clk);
    check("reset beat_valid", int'(beat_valid1), 0);
    check("reset frame_valid", int'(frame_valid1), 0);
    check("reset frame_max", int'(frame_max1), 0);
    rst_n = 1'b1;
    idle(2);

    // Single-beat frame, peak at lane 37
    v1 = '0;
    for (int k = 0; k < N1; k++) lane1(k, (k * 7) % 101);
    lane1(37, 500);
    send1(1'b1, 500, 37, 500, 37, 0, 0);
    idle(4);

    // All negative lanes clamp to zero; lane 0 wins the tie
    for (int k = 0; k < N1; k++) lane1(k, -5);
    send1(1'b1, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Equal peaks: lower lane wins
    v1 = '0; lane1(10, 200); lane1(50, 200);
    send1(1'b1, 200, 10, 200, 10, 0, 0);
    idle(4);

    // Four beats with a bubble; earliest beat keeps the tie
    v1 = '0; lane1(3, 30); send1(1'b0, 30, 3, 0, 0, 0, 0);
    v1 = '0; lane1(7, 90); send1(1'b0, 90, 7, 0, 0, 0, 0);
    idle(1);
    v1 = '0; lane1(2, 90); send1(1'b0, 90, 2, 0, 0, 0, 0);
    v1 = '0; lane1(1, 60); send1(1'b1, 60, 1, 90, 7, 1, 0);
    idle(4);

    // Back-to-back two-beat frames
    v1 = '0; lane1(5, 5);  send1(1'b0, 5, 5, 0, 0, 0, 0);
    v1 = '0; lane1(0, 3);  send1(1'b1, 3, 0, 5, 5, 0, 0);
    v1 = '0; lane1(4, 20); send1(1'b0, 20, 4, 0, 0, 0, 0);
    v1 = '0; lane1(9, 40); send1(1'b1, 40, 9, 40, 9, 1, 0);
    idle(4);

    // Mid-frame clear drops the same-cycle beat and the partial frame
    v1 = '0; lane1(1, 300); send1(1'b0, 300, 1, 0, 0, 0, 0);
    idle(4);
    @(negedge clk);
    v1 = '0; lane1(0, 999);
    in_data1 = v1; in_valid1 = 1'b1; in_last1 = 1'b1; clear1 = 1'b1;
    @(negedge clk);
    clear1 = 1'b0; in_valid1 = 1'b0; in_last1 = 1'b0;
    check("clear keeps frame_max", int'(frame_max1), 40);
    check("clear keeps frame_lane", int'(frame_lane1), 9);
    check("clear keeps frame_beat", int'(frame_beat1), 1);
    idle(3);
    v1 = '0; lane1(6, 12); send1(1'b1, 12, 6, 12, 6, 0, 0);
    idle(4);

    // Mid-frame reset discards the partial frame
    v1 = '0; lane1(2, 250); send1(1'b0, 250, 2, 0, 0, 0, 0);
    idle(4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst beat_valid", int'(beat_valid1), 0);
    check("rst beat_max", int'(beat_max1), 0);
    check("rst beat_lane", int'(beat_lane1), 0);
    check("rst frame_valid", int'(frame_valid1), 0);
    check("rst frame_max", int'(frame_max1), 0);
    check("rst frame_lane", int'(frame_lane1), 0);
    check("rst frame_beat", int'(frame_beat1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    v1 = '0; lane1(3, 8); send1(1'b1, 8, 3, 8, 3, 0, 0);
    idle(4);

`ifdef SW_SCORE_MAX_THRESH_EN
    // Threshold crossing on the second beat
    @(negedge clk);
    thresh1 = 16'd100;
    v1 = '0; lane1(0, 50);  send1(1'b0, 50, 0, 0, 0, 0, 0);
    v1 = '0; lane1(1, 120); send1(1'b0, 120, 1, 0, 0, 0, 0);
    eq1.push_back(cyc + 2 + LAT);
    v1 = '0; lane1(2, 150); send1(1'b1, 150, 2, 150, 2, 2, 1);
    idle(4);
    thresh1 = 16'hFFFF;
    idle(2);
`endif

    // Non-power-of-radix instance with a saturating 2-bit beat counter
    v2 = '0; lane2(9, 77); send2(1'b0, 77, 9, 0, 0, 0);
    for (int b = 1; b < 4; b++) begin
      v2 = '0; lane2(0, 1); send2(1'b0, 1, 0, 0, 0, 0);
    end
    v2 = '0; lane2(5, 80); send2(1'b1, 80, 5, 80, 5, 3);
    idle(4);

    for (int i = 0; i < 50 && (bq1.size() + fq1.size() + bq2.size() + fq2.size() + eq1.size()) != 0; i++)
      @(negedge clk);
    check("outstanding expectations", bq1.size() + fq1.size() + bq2.size() + fq2.size() + eq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
